sd_block_arbiter: RTL and testbench
===================================

SD_BLOCK_ARBITER -- requirements
Module: sd_block_arbiter

Interface
REQ-001 Parameter DATA_SIZE, default 4096: width of one SD data block in bits.
REQ-002 Parameter ADDR_SIZE, default 32: width of the block address.
REQ-003 Parameter TIMEOUT, default 65535: maximum number of cycles a granted transfer waits for ack (must be at least 2).
REQ-004 Port clock, input, 1: system clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Ports m0_cyc, m0_stb, m0_we, input, 1 each: requester 0 Wishbone cycle, strobe and write enable.
REQ-007 Ports m0_addr (ADDR_SIZE) and m0_dat_o (DATA_SIZE), input: requester 0 block address and write data.
REQ-008 Ports m0_dat_i (DATA_SIZE), m0_ack (1) and m0_err (1), output: requester 0 read data, acknowledge and timeout error.
REQ-009 Ports m1_* (requester 1), same set, widths and directions as m0_*.
REQ-010 Ports s_cyc, s_stb, s_we (1 each), s_addr (ADDR_SIZE) and s_dat_o (DATA_SIZE), output: toward the SD controller.
REQ-011 Ports s_dat_i (DATA_SIZE) and s_ack (1), input: from the SD controller.
REQ-012 Port arb_state, output, 2: current FSM state encoding, for debug (Idle=0, Bus0=1, Bus1=2, Error=3).

Function
REQ-013 The FSM SHALL have the states Idle, Bus0, Bus1 and Error.
REQ-014 A request from requester n is mn_cyc & mn_stb.
REQ-015 In Idle, with exactly one request, the FSM SHALL move to Bus of that requester on the next edge.
REQ-016 In Idle, with both requests, the FSM SHALL grant the requester that is not last_grant.
REQ-017 last_grant is a 1-bit register; it SHALL be updated to n whenever Bus n is left, for any reason.
REQ-018 In Idle and Error, s_cyc, s_stb, s_we, s_addr and s_dat_o SHALL be 0.
REQ-019 In Bus n, s_cyc, s_stb, s_we, s_addr and s_dat_o SHALL combinationally equal the corresponding mn_* inputs.
REQ-020 In Bus n, mn_ack = s_ack and mn_dat_i = s_dat_i; the other requester SHALL see ack=0, err=0, dat_i=0.
REQ-021 Outside Bus states, both mn_ack and both mn_dat_i SHALL be 0.
REQ-022 In Bus n, s_ack high SHALL return the FSM to Idle on the next edge; each grant carries exactly one transfer.
REQ-023 As a consequence of REQ-022, there SHALL be at least one Idle cycle between consecutive grants.
REQ-024 In Bus n, if mn_cyc drops without s_ack, the FSM SHALL return to Idle on the next edge (abort).
REQ-025 A wait counter SHALL clear on entry to each Bus state.
REQ-026 The wait counter SHALL increment each Bus cycle without s_ack, saturating at TIMEOUT.
REQ-027 If the wait counter reaches TIMEOUT-1 with no s_ack, the FSM SHALL enter Error.
REQ-028 Error SHALL last exactly one cycle, during which mn_err=1 for the timed-out requester only; the FSM then goes to Idle.
REQ-029 If s_ack and the timeout condition occur in the same cycle, ack SHALL win: no err, and the FSM goes to Idle.
REQ-030 If s_ack and an mn_cyc drop occur in the same cycle, the ack SHALL be forwarded and the FSM goes to Idle.
REQ-031 A request from the non-granted requester SHALL be ignored until Idle; requests are not latched.
REQ-032 Unreachable state encodings SHALL fall back to Idle on the next edge.

Reset
REQ-033 While reset is high, the FSM SHALL be in Idle, last_grant=1 (so requester 0 wins the first tie), and the wait counter=0.
REQ-034 While reset is high, all outputs SHALL be 0; reset asserted mid-transfer SHALL drop s_cyc/s_stb immediately, independent of clock.

Verification
REQ-035 m0 write (we=1, addr=0x10, data=DataBlockA); s_ack after 5 cycles -> s_addr=0x10, s_dat_o=DataBlockA, m0_ack for one cycle, then Idle; m1_ack stays 0.
REQ-036 m0 and m1 both request reads from Idle after reset -> m0 granted first, then Idle for one cycle, then m1 granted; m1_dat_i equals s_dat_i at its ack.
REQ-037 Both requesters request continuously for 4 transfers -> grant order 0,1,0,1; arb_state sequence 1,0,2,0,1,0,2.
REQ-038 TIMEOUT=8, m1 request with s_ack never asserted -> Error entered after 7 Bus1 cycles, m1_err=1 for exactly one cycle, s_cyc=0 in Error, then Idle.
REQ-039 TIMEOUT=8, s_ack asserted in the 7th Bus cycle -> ack forwarded, m_err stays 0.
REQ-040 m0 drops cyc in Bus0 with no ack -> Idle next cycle; reset pulsed during Bus1 -> s_cyc=0 immediately, arb_state=0.

Source files
------------

// File: rtl/sd_block_arbiter.sv
// Two-requester Wishbone arbiter in front of a single SD block controller.
// One transfer per grant, alternating priority on ties, and a per-grant wait
// timer that reports a one-cycle error to the requester that timed out.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no grant; slave side driven to 0, picks next requester
// BUS0    | requester 0 owns the slave port until ack, abort or timeout
// BUS1    | requester 1 owns the slave port until ack, abort or timeout
// ERROR   | one cycle; err pulsed to the requester that just timed out
module sd_block_arbiter #(
    parameter int DATA_SIZE = 4096,
    parameter int ADDR_SIZE = 32,
    parameter int TIMEOUT   = 65535
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 m0_cyc,
    input  logic                 m0_stb,
    input  logic                 m0_we,
    input  logic [ADDR_SIZE-1:0] m0_addr,
    input  logic [DATA_SIZE-1:0] m0_dat_o,
    output logic [DATA_SIZE-1:0] m0_dat_i,
    output logic                 m0_ack,
    output logic                 m0_err,
    input  logic                 m1_cyc,
    input  logic                 m1_stb,
    input  logic                 m1_we,
    input  logic [ADDR_SIZE-1:0] m1_addr,
    input  logic [DATA_SIZE-1:0] m1_dat_o,
    output logic [DATA_SIZE-1:0] m1_dat_i,
    output logic                 m1_ack,
    output logic                 m1_err,
    output logic                 s_cyc,
    output logic                 s_stb,
    output logic                 s_we,
    output logic [ADDR_SIZE-1:0] s_addr,
    output logic [DATA_SIZE-1:0] s_dat_o,
    input  logic [DATA_SIZE-1:0] s_dat_i,
    input  logic                 s_ack,
    output logic [1:0]           arb_state
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS0  = 2'd1,
        ST_BUS1  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic [CW-1:0] wait_q, wait_d;
    logic [CW-1:0] wait_inc;
    logic          timeout_hit;
    logic          req0, req1;

    assign req0        = m0_cyc & m0_stb;
    assign req1        = m1_cyc & m1_stb;
    // Saturating increment; the counter is only meaningful while a Bus state is held.
    assign wait_inc    = (wait_q == CW'(TIMEOUT)) ? wait_q : wait_q + 1'b1;
    // The counter would reach TIMEOUT-1 on this edge, so this is the last Bus cycle.
    assign timeout_hit = (wait_q == CW'(TIMEOUT - 2));
    assign arb_state   = state_q;

    // State, priority memory and wait counter; reset forces Idle so outputs drop at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            wait_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wait_q       <= wait_d;
        end
    end

    // Next-state selection and the combinational bus multiplexing.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wait_d       = '0;
        s_cyc        = 1'b0;
        s_stb        = 1'b0;
        s_we         = 1'b0;
        s_addr       = '0;
        s_dat_o      = '0;
        m0_dat_i     = '0;
        m0_ack       = 1'b0;
        m0_err       = 1'b0;
        m1_dat_i     = '0;
        m1_ack       = 1'b0;
        m1_err       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0 && req1) begin
                    state_d = last_grant_q ? ST_BUS0 : ST_BUS1;
                end else if (req0) begin
                    state_d = ST_BUS0;
                end else if (req1) begin
                    state_d = ST_BUS1;
                end
            end
            ST_BUS0: begin
                s_cyc    = m0_cyc;
                s_stb    = m0_stb;
                s_we     = m0_we;
                s_addr   = m0_addr;
                s_dat_o  = m0_dat_o;
                m0_ack   = s_ack;
                m0_dat_i = s_dat_i;
                if (s_ack || !m0_cyc) begin
                    state_d      = ST_IDLE;
                    last_grant_d = 1'b0;
                end else if (timeout_hit) begin
                    state_d      = ST_ERROR;
                    last_grant_d = 1'b0;
                end else begin
                    wait_d = wait_inc;
                end
            end
            ST_BUS1: begin
                s_cyc    = m1_cyc;
                s_stb    = m1_stb;
                s_we     = m1_we;
                s_addr   = m1_addr;
                s_dat_o  = m1_dat_o;
                m1_ack   = s_ack;
                m1_dat_i = s_dat_i;
                if (s_ack || !m1_cyc) begin
                    state_d      = ST_IDLE;
                    last_grant_d = 1'b1;
                end else if (timeout_hit) begin
                    state_d      = ST_ERROR;
                    last_grant_d = 1'b1;
                end else begin
                    wait_d = wait_inc;
                end
            end
            ST_ERROR: begin
                m0_err  = ~last_grant_q;
                m1_err  = last_grant_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sd_block_arbiter.sv
// Directed bench for sd_block_arbiter with TIMEOUT=8 and default data/address widths.
module tb_sd_block_arbiter;

    localparam int DS = 4096;
    localparam int AS = 32;

    localparam logic [DS-1:0] BLK_A = {128{32'hA5A5_0001}};
    localparam logic [DS-1:0] BLK_B = {128{32'h0B0B_0002}};
    localparam logic [DS-1:0] BLK_C = {128{32'hC3C3_0003}};
    localparam logic [DS-1:0] BLK_D = {128{32'hD4D4_0004}};

    logic          clock = 1'b0;
    logic          reset;
    logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [AS-1:0] m0_addr, m1_addr, s_addr;
    logic [DS-1:0] m0_dat_o, m1_dat_o, m0_dat_i, m1_dat_i, s_dat_o, s_dat_i;
    logic          m0_ack, m0_err, m1_ack, m1_err;
    logic          s_cyc, s_stb, s_we, s_ack;
    logic [1:0]    arb_state;

    int checks   = 0;
    int failures = 0;

    sd_block_arbiter #(.DATA_SIZE(DS), .ADDR_SIZE(AS), .TIMEOUT(8)) dut (
        .clock(clock), .reset(reset),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_dat_o(m0_dat_o), .m0_dat_i(m0_dat_i), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_dat_o(m1_dat_o), .m1_dat_i(m1_dat_i), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr),
        .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack(s_ack), .arb_state(arb_state)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [DS-1:0] obs, input logic [DS-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed(low32)=%0h expected(low32)=%0h", tag, obs[31:0], exp[31:0]);
        end
    endtask

    task automatic m0_set(input logic cyc, input logic we, input logic [AS-1:0] a, input logic [DS-1:0] d);
        m0_cyc = cyc; m0_stb = cyc; m0_we = we; m0_addr = a; m0_dat_o = d;
    endtask

    task automatic m1_set(input logic cyc, input logic we, input logic [AS-1:0] a, input logic [DS-1:0] d);
        m1_cyc = cyc; m1_stb = cyc; m1_we = we; m1_addr = a; m1_dat_o = d;
    endtask

    initial begin
        logic [1:0] seq [7];
        seq = '{2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2};

        reset = 1'b1;
        m0_set(1'b1, 1'b1, 32'h44, BLK_D);
        m1_set(1'b0, 1'b0, '0, '0);
        s_ack = 1'b0; s_dat_i = BLK_C;
        tick();
        tick();
        chk("rst_state", arb_state, 0);
        chk("rst_s_cyc", s_cyc, 0);
        chk("rst_s_stb", s_stb, 0);
        chkd("rst_s_dat_o", s_dat_o, '0);
        chkd("rst_m0_dat_i", m0_dat_i, '0);
        reset = 1'b0;
        m0_set(1'b0, 1'b0, '0, '0);
        tick();
        chk("idle_no_req", arb_state, 0);

        // m0 write, ack on the fifth Bus0 cycle
        m0_set(1'b1, 1'b1, 32'h10, BLK_A);
        tick();
        chk("wr_state", arb_state, 1);
        chk("wr_s_cyc", s_cyc, 1);
        chk("wr_s_we", s_we, 1);
        chk("wr_s_addr", s_addr, 32'h10);
        chkd("wr_s_dat_o", s_dat_o, BLK_A);
        chk("wr_m0_ack_wait", m0_ack, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("wr_still_bus0", arb_state, 1);
        s_ack = 1'b1;
        #1;
        chk("wr_m0_ack", m0_ack, 1);
        chk("wr_m1_ack", m1_ack, 0);
        tick();
        s_ack = 1'b0;
        m0_set(1'b0, 1'b0, '0, '0);
        #1;
        chk("wr_back_idle", arb_state, 0);
        chk("wr_m0_ack_low", m0_ack, 0);

        // Fresh reset, then simultaneous reads: m0 first, one Idle, then m1
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        m0_set(1'b1, 1'b0, 32'h20, '0);
        m1_set(1'b1, 1'b0, 32'h30, '0);
        tick();
        chk("tie_m0_first", arb_state, 1);
        chk("tie_s_addr_m0", s_addr, 32'h20);
        chk("tie_s_we", s_we, 0);
        s_ack = 1'b1; s_dat_i = BLK_B;
        #1;
        chkd("tie_m0_dat_i", m0_dat_i, BLK_B);
        chkd("tie_m1_dat_i_zero", m1_dat_i, '0);
        chk("tie_m1_ack_zero", m1_ack, 0);
        tick();
        s_ack = 1'b0;
        m0_set(1'b0, 1'b0, '0, '0);
        #1;
        chk("tie_gap_idle", arb_state, 0);
        tick();
        chk("tie_m1_second", arb_state, 2);
        chk("tie_s_addr_m1", s_addr, 32'h30);
        s_ack = 1'b1; s_dat_i = BLK_C;
        #1;
        chkd("tie_m1_dat_i", m1_dat_i, BLK_C);
        chk("tie_m1_ack", m1_ack, 1);
        chk("tie_m0_ack_zero", m0_ack, 0);
        tick();
        s_ack = 1'b0;
        m1_set(1'b0, 1'b0, '0, '0);
        #1;
        chk("tie_end_idle", arb_state, 0);

        // Both requesting continuously, single-cycle acks
        m0_set(1'b1, 1'b0, 32'h40, '0);
        m1_set(1'b1, 1'b0, 32'h50, '0);
        for (int i = 0; i < 7; i++) begin
            tick();
            s_ack = 1'b0;
            #1;
            chk($sformatf("rr_state_%0d", i), arb_state, seq[i]);
            if (seq[i] != 2'd0) s_ack = 1'b1;
        end
        chk("rr_last_addr", s_addr, 32'h50);
        tick();
        s_ack = 1'b0;
        m0_set(1'b0, 1'b0, '0, '0);
        m1_set(1'b0, 1'b0, '0, '0);
        #1;
        chk("rr_end_idle", arb_state, 0);

        // m1 timeout: 7 Bus1 cycles, one Error cycle, then Idle
        m1_set(1'b1, 1'b1, 32'h60, BLK_D);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("to_bus1_%0d", i), arb_state, 2);
        end
        chk("to_no_err_yet", m1_err, 0);
        tick();
        chk("to_error_state", arb_state, 3);
        chk("to_m1_err", m1_err, 1);
        chk("to_m0_err", m0_err, 0);
        chk("to_s_cyc_err", s_cyc, 0);
        chk("to_m1_ack_err", m1_ack, 0);
        m1_set(1'b0, 1'b0, '0, '0);
        tick();
        chk("to_idle", arb_state, 0);
        chk("to_m1_err_off", m1_err, 0);

        // Ack on the seventh Bus0 cycle beats the timeout
        m0_set(1'b1, 1'b0, 32'h70, '0);
        for (int i = 0; i < 7; i++) tick();
        chk("ackwin_bus0", arb_state, 1);
        s_ack = 1'b1; s_dat_i = BLK_D;
        #1;
        chk("ackwin_m0_ack", m0_ack, 1);
        chkd("ackwin_m0_dat_i", m0_dat_i, BLK_D);
        tick();
        s_ack = 1'b0;
        m0_set(1'b0, 1'b0, '0, '0);
        #1;
        chk("ackwin_idle", arb_state, 0);
        chk("ackwin_m0_err", m0_err, 0);
        tick();
        chk("ackwin_m0_err_next", m0_err, 0);

        // m0 abort by dropping cyc
        m0_set(1'b1, 1'b1, 32'h80, BLK_A);
        tick();
        tick();
        chk("abort_bus0", arb_state, 1);
        m0_cyc = 1'b0;
        #1;
        chk("abort_s_cyc", s_cyc, 0);
        tick();
        chk("abort_idle", arb_state, 0);
        m0_set(1'b0, 1'b0, '0, '0);

        // Asynchronous reset in the middle of a Bus1 grant
        m1_set(1'b1, 1'b0, 32'h90, '0);
        tick();
        chk("rstmid_bus1", arb_state, 2);
        chk("rstmid_s_cyc_on", s_cyc, 1);
        #2 reset = 1'b1;
        #1;
        chk("rstmid_s_cyc", s_cyc, 0);
        chk("rstmid_s_stb", s_stb, 0);
        chk("rstmid_state", arb_state, 0);
        #1 reset = 1'b0;
        m1_set(1'b0, 1'b0, '0, '0);
        tick();

        // After reset the tie again goes to m0
        m0_set(1'b1, 1'b0, 32'hA0, '0);
        m1_set(1'b1, 1'b0, 32'hB0, '0);
        tick();
        chk("rst_tie_m0", arb_state, 1);
        m0_set(1'b0, 1'b0, '0, '0);
        m1_set(1'b0, 1'b0, '0, '0);
        tick();
        chk("rst_tie_abort_idle", arb_state, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
